// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Control FSM that drives an external counter datapath through a counting
//   run: clear it, enable it until it reaches a captured terminal count, then
//   report completion. The FSM can pause, abort or auto-reload.
//
// Ports
//   clk          single clock, all state on posedge
//   reset        asynchronous active-low reset
//   start        begin a run (only looked at in IDLE)
//   pause        level, freezes an active run
//   abort        level, cancels any run in progress
//   auto_reload  restart with the same limit after each completed run
//   limit        terminal count, captured when start is accepted
//   q            current value of the controlled counter
//   cnt_clr      synchronous clear command to the counter
//   cnt_en       count enable to the counter (combinational)
//   busy         high in every state except IDLE
//   done         one-cycle pulse per completed run
//   runs         saturating count of completed runs
module counter_sequencer #(
  parameter int WIDTH  = 4,
  parameter int RUNS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic              auto_reload,
  input  logic [WIDTH-1:0]  limit,
  input  logic [WIDTH-1:0]  q,
  output logic              cnt_clr,
  output logic              cnt_en,
  output logic              busy,
  output logic              done,
  output logic [RUNS_W-1:0] runs
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] limit_r;
  logic             term;

  assign term = (q == limit_r);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      limit_r <= '0;
      runs    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            limit_r <= limit;
            state   <= CLEAR;
          end
        end
        CLEAR: state <= RUN;
        RUN: begin
          // terminal beats pause so a run that lands on limit always completes
          if (abort)      state <= IDLE;
          else if (term)  state <= DONE;
          else if (pause) state <= PAUSE;
        end
        PAUSE: begin
          if (abort)       state <= IDLE;
          else if (!pause) state <= RUN;
        end
        DONE: begin
          // done is already visible this cycle, so the run counts even on abort
          if (runs != {RUNS_W{1'b1}}) runs <= runs + 1'b1;
          if (abort)            state <= IDLE;
          else if (auto_reload) state <= CLEAR;
          else                  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cnt_clr = (state == CLEAR);
  assign done    = (state == DONE);
  assign busy    = (state != IDLE);
  // gated by term so the datapath stops exactly at limit_r
  assign cnt_en  = (state == RUN) && !pause && !abort && !term;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;
  localparam int WIDTH  = 4;
  localparam int RUNS_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start, pause, abort, auto_reload;
  logic [WIDTH-1:0]  limit, q;
  logic              cnt_clr, cnt_en, busy, done;
  logic [RUNS_W-1:0] runs;

  int tests = 0;
  int fails = 0;
  int n_clr, n_en, n_done, n_idle;
  int sb[$];

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(WIDTH), .RUNS_W(RUNS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .abort(abort),
    .auto_reload(auto_reload), .limit(limit), .q(q), .cnt_clr(cnt_clr),
    .cnt_en(cnt_en), .busy(busy), .done(done), .runs(runs)
  );

  // counter datapath being sequenced
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       q <= '0;
    else if (cnt_clr) q <= '0;
    else if (cnt_en)  q <= q + 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    n_clr = 0; n_en = 0; n_done = 0; n_idle = 0;
  endtask

  task automatic wait_done(input string tag, input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (done) break;
    end
    check(tag, done, 1);
  endtask

  task automatic wait_q(input string tag, input logic [WIDTH-1:0] v, input int max);
    for (int i = 0; i < max; i++) begin
      tick();
      if (q == v) break;
    end
    check(tag, q, v);
  endtask

  // monitor + scoreboard: every done pulse pops the expected terminal value
  always @(negedge clk) begin
    if (reset) begin
      if (cnt_clr) n_clr++;
      if (cnt_en)  n_en++;
      if (!busy)   n_idle++;
      if (done) begin
        n_done++;
        if (sb.size() == 0) check("unexpected_done", done, 0);
        else check("sb_done_q", q, sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 0; pause = 0; abort = 0; auto_reload = 0; limit = '0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clr", cnt_clr, 0);
    check("rst_en", cnt_en, 0);
    check("rst_runs", runs, 0);
    tick(); tick();
    reset = 1'b1;
    clr_cnt();

    // basic run, limit 5
    limit = 5; start = 1; sb.push_back(5);
    tick(); start = 0;
    wait_done("t1_done", 20);
    check("t1_busy_in_done", busy, 1);
    tick();
    check("t1_busy_fall", busy, 0);
    check("t1_runs", runs, 1);
    check("t1_nclr", n_clr, 1);
    check("t1_nen", n_en, 5);
    check("t1_q", q, 5);
    check("t1_ndone", n_done, 1);

    // pause at q=1 for 4 cycles, limit 3
    clr_cnt();
    limit = 3; start = 1; sb.push_back(3);
    tick(); start = 0;
    wait_q("t2_q1", 1, 10);
    pause = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_en_paused", cnt_en, 0);
      check("t2_q_hold", q, 1);
      tick();
    end
    pause = 0;
    wait_done("t2_done", 20);
    check("t2_nen", n_en, 3);
    tick();
    check("t2_ndone", n_done, 1);
    check("t2_runs", runs, 2);

    // auto reload, 3 runs of limit 2, from fresh reset
    reset = 0; #1; reset = 1;
    check("t3_runs_rst", runs, 0);
    limit = 2; auto_reload = 1; start = 1;
    repeat (3) sb.push_back(2);
    tick(); start = 0;
    clr_cnt();
    for (int r = 0; r < 3; r++) wait_done("t3_done", 20);
    auto_reload = 0;
    tick();
    check("t3_ndone", n_done, 3);
    check("t3_nclr", n_clr, 3);
    check("t3_busy_high", n_idle, 0);
    check("t3_runs", runs, 3);
    check("t3_idle", busy, 0);

    // abort at q=4, limit 7
    clr_cnt();
    limit = 7; start = 1;
    tick(); start = 0;
    wait_q("t4_q4", 4, 20);
    abort = 1;
    #1;
    check("t4_en_abort", cnt_en, 0);
    tick();
    check("t4_idle", busy, 0);
    check("t4_runs", runs, 3);
    check("t4_ndone", n_done, 0);
    abort = 0;

    // limit 0
    clr_cnt();
    limit = 0; start = 1; sb.push_back(0);
    tick(); start = 0;
    check("t5_clr", cnt_clr, 1);
    tick();
    check("t5_nodone_run", done, 0);
    tick();
    check("t5_done", done, 1);
    check("t5_nen", n_en, 0);
    tick();
    check("t5_idle", busy, 0);
    check("t5_runs", runs, 4);

    // limit not resampled, start ignored mid-run
    clr_cnt();
    limit = 4; start = 1; sb.push_back(4);
    tick(); start = 0;
    tick();
    limit = 9; start = 1;
    wait_done("t6_done", 20);
    start = 0;
    check("t6_q", q, 4);
    tick();
    check("t6_idle", busy, 0);
    check("t6_nclr", n_clr, 1);

    // async reset mid-run
    limit = 7; start = 1;
    tick(); start = 0;
    wait_q("t7_q3", 3, 20);
    #2 reset = 0;
    #1;
    check("t7_busy", busy, 0);
    check("t7_en", cnt_en, 0);
    check("t7_clr", cnt_clr, 0);
    check("t7_done", done, 0);
    check("t7_runs", runs, 0);
    #2 reset = 1;

    // first start after reset accepted, then saturate runs
    clr_cnt();
    limit = 0; auto_reload = 1; start = 1;
    repeat (300) sb.push_back(0);
    tick(); start = 0;
    check("t8_first_start", cnt_clr, 1);
    for (int r = 0; r < 300; r++) wait_done("t8_done", 10);
    auto_reload = 0;
    tick();
    check("t8_runs_sat", runs, 255);
    check("t8_idle", busy, 0);
    check("t8_ndone", n_done, 300);
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: WIDTH, 4, width of the count value and limit.
REQ-002 Parameter: RUNS_W, 8, width of the completed-run counter.
REQ-003 Port: clk  in  1  single clock; all state changes on posedge clk.
REQ-004 Port: reset  in  1  asynchronous, active-low (0 = reset asserted); the only reset.
REQ-005 Port: start  in  1  request to begin a counting run; sampled in IDLE only.
REQ-006 Port: pause  in  1  level; freezes an active run while high.
REQ-007 Port: abort  in  1  level; cancels any run in progress.
REQ-008 Port: auto_reload  in  1  1 = restart automatically after each completed run.
REQ-009 Port: limit  in  WIDTH  terminal count; captured when start is accepted.
REQ-010 Port: q  in  WIDTH  current value of the controlled counter datapath.
REQ-011 Port: cnt_clr  out  1  synchronous clear command to the counter datapath.
REQ-012 Port: cnt_en  out  1  count-enable command to the counter datapath.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: done  out  1  one-cycle pulse per completed run.
REQ-015 Port: runs  out  RUNS_W  number of completed runs, saturating.

Function
REQ-016 The FSM SHALL have the states IDLE, CLEAR, RUN, PAUSE and DONE, all registered.
REQ-017 IDLE: if start=1 and abort=0, the block SHALL capture limit into limit_r and go to CLEAR; otherwise it SHALL stay in IDLE.
REQ-018 CLEAR: cnt_clr SHALL be 1 for exactly this one cycle, then the FSM SHALL go to RUN.
REQ-019 RUN, in priority order: abort -> IDLE; q==limit_r -> DONE; pause -> PAUSE; otherwise stay in RUN.
REQ-020 cnt_en SHALL be combinational: (state==RUN) and pause=0 and abort=0 and q!=limit_r, so the counter never advances past limit_r.
REQ-021 PAUSE: cnt_en=0; abort -> IDLE; pause=0 -> RUN; otherwise stay in PAUSE.
REQ-022 DONE: done=1 for this one cycle and runs SHALL increment, holding at 2^RUNS_W-1 once it saturates.
REQ-023 DONE exit: abort -> IDLE; auto_reload=1 -> CLEAR, reusing the same limit_r; auto_reload=0 -> IDLE.
REQ-024 start SHALL be ignored outside IDLE, and limit SHALL NOT be re-sampled mid-run.
REQ-025 When limit=0, the sequence SHALL be CLEAR -> RUN -> DONE with cnt_en never asserted.
REQ-026 Abort SHALL never produce done and SHALL leave runs unchanged; abort in DONE still counts that run, because done is already asserted.
REQ-027 When pause and terminal are both true in RUN, terminal SHALL win and the FSM SHALL go to DONE.
REQ-028 cnt_clr, done and busy SHALL be decoded from the registered state (Moore outputs).

Reset
REQ-029 While reset=0: state=IDLE, limit_r=0, runs=0, cnt_clr=0, cnt_en=0, busy=0, done=0, all asynchronously.
REQ-030 Reset asserted mid-run SHALL immediately force the REQ-029 values, with no done pulse.
REQ-031 After reset deasserts, the first start SHALL be accepted on the first posedge with start=1.

Verification
REQ-032 limit=5, auto_reload=0, one-cycle start -> cnt_clr pulses once, cnt_en high for 5 cycles, q ends at 5, done pulses once, runs=1, busy falls the cycle after done.
REQ-033 limit=3, pause high for 4 cycles after q=1 -> cnt_en low for exactly those cycles, q holds at 1, run completes at q=3, done pulses once.
REQ-034 limit=2, auto_reload=1, for 3 runs -> three done pulses, each followed by one cnt_clr cycle; runs=3; busy stays high throughout.
REQ-035 limit=7, abort at q=4 -> IDLE next cycle, no done, runs unchanged, cnt_en low the same cycle.
REQ-036 limit=0 -> done two cycles after the CLEAR cycle begins, cnt_en never high; limit=9 applied to an already-running limit=4 run -> run ends at q=4.
REQ-037 reset=0 driven mid-RUN, between clock edges -> all outputs at reset values before the next posedge; with auto_reload=1 and 300 runs, runs saturates at 255.
